// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 4;

   // Number of storage entries for a given address width.
   function automatic int unsigned fifo_depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_param.
// SYNC_FIFO_FWFT_EN: defined -> combinational read port, undefined -> registered read port.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port; contents are never cleared.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented without waiting for a read strobe.
   assign rdata = mem_q[raddr];

   logic unused_fwft;
   assign unused_fwft = ^{rst, re};
`else
   logic [DATA_W-1:0] rdata_d, rdata_q;

   // Load the addressed word on a read, hold otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   // Registered read data, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, almost flags and sticky errors.
// SYNC_FIFO_FWFT_EN: defined -> first-word-fall-through read, undefined -> registered read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned AFULL_TH  = (32'd1 << ADDR_W) - 32'd2,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic [DATA_W-1:0] wdata,
   output logic              wfull,
   output logic              walmost_full,
   input  logic              rinc,
   output logic [DATA_W-1:0] rdata,
   output logic              rempty,
   output logic              ralmost_empty,
   output logic [ADDR_W:0]   count,
   output logic              wovf,
   output logic              rudf
);

   localparam int unsigned PTR_W      = ADDR_W + 1;
   localparam logic [ADDR_W:0] AFULL_CNT  = PTR_W'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_CNT = PTR_W'(AEMPTY_TH);

   logic [ADDR_W:0] wptr_d, wptr_q, rptr_d, rptr_q, count_d, count_q;
   logic            wfull_d, wfull_q, rempty_d, rempty_q;
   logic            walmost_full_d, walmost_full_q, ralmost_empty_d, ralmost_empty_q;
   logic            wovf_d, wovf_q, rudf_d, rudf_q;
   logic            wr_acc, rd_acc;

   assign wr_acc = winc && !wfull_q;
   assign rd_acc = rinc && !rempty_q;

   // Next pointers, status derived from next pointers, sticky error capture.
   always_comb begin
      wptr_d          = wptr_q + PTR_W'(wr_acc);
      rptr_d          = rptr_q + PTR_W'(rd_acc);
      count_d         = wptr_d - rptr_d;
      rempty_d        = (wptr_d == rptr_d);
      wfull_d         = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                        (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
      walmost_full_d  = (count_d >= AFULL_CNT);
      ralmost_empty_d = (count_d <= AEMPTY_CNT);
      wovf_d          = wovf_q | (winc & wfull_q);
      rudf_d          = rudf_q | (rinc & rempty_q);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q          <= '0;
         rptr_q          <= '0;
         count_q         <= '0;
         rempty_q        <= 1'b1;
         wfull_q         <= 1'b0;
         walmost_full_q  <= 1'b0;
         ralmost_empty_q <= 1'b1;
         wovf_q          <= 1'b0;
         rudf_q          <= 1'b0;
      end else begin
         wptr_q          <= wptr_d;
         rptr_q          <= rptr_d;
         count_q         <= count_d;
         rempty_q        <= rempty_d;
         wfull_q         <= wfull_d;
         walmost_full_q  <= walmost_full_d;
         ralmost_empty_q <= ralmost_empty_d;
         wovf_q          <= wovf_d;
         rudf_q          <= rudf_d;
      end
   end

   // Storage; accesses are suppressed while reset is asserted.
   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && !rst),
      .waddr (wptr_q[ADDR_W-1:0]),
      .wdata (wdata),
      .re    (rd_acc && !rst),
      .raddr (rptr_q[ADDR_W-1:0]),
      .rdata (rdata)
   );

   assign count         = count_q;
   assign rempty        = rempty_q;
   assign wfull         = wfull_q;
   assign walmost_full  = walmost_full_q;
   assign ralmost_empty = ralmost_empty_q;
   assign wovf          = wovf_q;
   assign rudf          = rudf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
// Honours SYNC_FIFO_FWFT_EN for the read-data expectations.
module tb_sync_fifo_param;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          winc = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          rinc = 1'b0;
   logic          wfull, walmost_full, rempty, ralmost_empty, wovf, rudf;
   logic [DW-1:0] rdata;
   logic [AW:0]   count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_rdata = '0;
   bit            m_wovf = 1'b0;
   bit            m_rudf = 1'b0;

   sync_fifo_param #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .winc          (winc),
      .wdata         (wdata),
      .wfull         (wfull),
      .walmost_full  (walmost_full),
      .rinc          (rinc),
      .rdata         (rdata),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .count         (count),
      .wovf          (wovf),
      .rudf          (rudf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: decisions use occupancy before the edge.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_rdata = '0;
         m_wovf  = 1'b0;
         m_rudf  = 1'b0;
      end else begin
         int  n;
         bit  do_w, do_r;
         n    = mq.size();
         do_w = winc && (n != DEPTH);
         do_r = rinc && (n != 0);
         if (winc && n == DEPTH) m_wovf = 1'b1;
         if (rinc && n == 0)     m_rudf = 1'b1;
         if (do_r) m_rdata = mq.pop_front();
         if (do_w) mq.push_back(wdata);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = mq.size();
         chk("count",         int'(count),         n);
         chk("rempty",        int'(rempty),        int'(n == 0));
         chk("wfull",         int'(wfull),         int'(n == DEPTH));
         chk("walmost_full",  int'(walmost_full),  int'(n >= 6));
         chk("ralmost_empty", int'(ralmost_empty), int'(n <= 2));
         chk("wovf",          int'(wovf),          int'(m_wovf));
         chk("rudf",          int'(rudf),          int'(m_rudf));
`ifdef SYNC_FIFO_FWFT_EN
         if (n != 0) chk("rdata_head", int'(rdata), int'(mq[0]));
`else
         chk("rdata", int'(rdata), int'(m_rdata));
`endif
      end
   end

   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
      winc  = w;
      wdata = d;
      rinc  = r;
      @(posedge clk);
      #1;
      winc = 1'b0;
      rinc = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();
      chk_en = 1'b1;
      cyc(1'b0, '0, 1'b0);
      chk("rst_count", int'(count), 0);
      chk("rst_rempty", int'(rempty), 1);
      chk("rst_ralmost_empty", int'(ralmost_empty), 1);
      chk("rst_wfull", int'(wfull), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_errs", int'({wovf, rudf}), 0);

      // Fill to full
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, DW'(8'h11 * (i + 1)), 1'b0);
         chk("fill_count", int'(count), i + 1);
         if (i == 4) chk("afull_at5", int'(walmost_full), 0);
         if (i == 5) chk("afull_at6", int'(walmost_full), 1);
      end
      chk("full_after8", int'(wfull), 1);
      cyc(1'b1, 8'h99, 1'b0);
      chk("ovf_set", int'(wovf), 1);
      chk("ovf_count", int'(count), 8);

      // Drain in order
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
         chk("drain_data", int'(rdata), 8'h11 * (i + 1));
`endif
      end
      chk("drain_empty", int'(rempty), 1);

      // Wrap-around
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(i + 1), 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0);
      for (int i = 0; i < 6; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("wrap_head", int'(rdata), 8'hA0 + i);
         cyc(1'b0, '0, 1'b1);
`else
         cyc(1'b0, '0, 1'b1);
         chk("wrap_data", int'(rdata), 8'hA0 + i);
`endif
      end
      chk("wrap_count", int'(count), 0);
      chk("wrap_empty", int'(rempty), 1);

      // Simultaneous write+read at count 4
      for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'hD0 + i), 1'b1);
      chk("simul_count", int'(count), 4);

      // Mid-stream reset
      cyc(1'b1, 8'hE0, 1'b0);
      chk("pre_rst_count", int'(count), 5);
      do_reset();
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_rempty", int'(rempty), 1);
      chk("mid_rst_wovf", int'(wovf), 0);

      // Simultaneous write+read on empty: read rejected
      cyc(1'b1, 8'h3C, 1'b1);
      chk("empty_simul_rudf", int'(rudf), 1);
      chk("empty_simul_count", int'(count), 1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_new_head", int'(rdata), 8'h3C);
      cyc(1'b0, '0, 1'b1);
`else
      cyc(1'b0, '0, 1'b1);
      chk("post_rst_data", int'(rdata), 8'h3C);
`endif
      chk("post_rst_empty", int'(rempty), 1);

`ifdef SYNC_FIFO_FWFT_EN
      // Fall-through visibility before any read strobe
      cyc(1'b1, 8'h5A, 1'b0);
      chk("fwft_rempty", int'(rempty), 0);
      chk("fwft_rdata", int'(rdata), 8'h5A);
      cyc(1'b0, '0, 1'b1);
      chk("fwft_pop_empty", int'(rempty), 1);
`endif

      // Read on empty with no write leaves data stable
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      chk("idle_count", int'(count), 0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
